// File: rtl/connect4_pkg.sv
// Shared constants, cell/winner codes and FSM state encoding for the 4x4 Connect4 turn controller.
package connect4_pkg;

  localparam int          NUM_ROWS    = 4;
  localparam int          NUM_COLS    = 4;
  localparam logic [4:0]  POS_INVALID = 5'b11111;
  localparam logic [4:0]  MAX_MOVES   = 5'd16;
  localparam logic [2:0]  COL_FULL    = 3'd4;

  localparam logic [1:0]  CELL_EMPTY  = 2'b00;
  localparam logic [1:0]  CELL_A      = 2'b01;
  localparam logic [1:0]  CELL_B      = 2'b10;

  localparam logic [1:0]  WIN_NONE    = 2'b00;
  localparam logic [1:0]  WIN_A       = 2'b01;
  localparam logic [1:0]  WIN_B       = 2'b10;
  localparam logic [1:0]  WIN_DRAW    = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DROP    = 3'd1,
    CHECK   = 3'd2,
    RELEASE = 3'd3,
    OVER    = 3'd4
  } state_t;

  // Player 0 plays A pieces, player 1 plays B pieces; winner codes share the encoding.
  function automatic logic [1:0] player_cell(input logic player);
    return player ? CELL_B : CELL_A;
  endfunction

endpackage

// File: rtl/connect4_win_checker.sv
// Combinational 4-in-a-row detector: flags a win when any row, column or main diagonal
// of the 4x4 board is entirely filled with the given cell code.
module connect4_win_checker
  import connect4_pkg::*;
(
  input  logic [31:0] board_state,
  input  logic [1:0]  cell_code,
  output logic        win
);

  logic [15:0] own;

  always_comb begin
    own = '0;
    for (int p = 0; p < 16; p++) begin
      own[p] = (board_state[2*p +: 2] == cell_code);
    end
  end

  assign win = (&own[3:0])   | (&own[7:4])  | (&own[11:8]) | (&own[15:12])
             | (own[0] & own[4] & own[8]  & own[12])
             | (own[1] & own[5] & own[9]  & own[13])
             | (own[2] & own[6] & own[10] & own[14])
             | (own[3] & own[7] & own[11] & own[15])
             | (own[0] & own[5] & own[10] & own[15])
             | (own[3] & own[6] & own[9]  & own[12]);

endmodule

// File: rtl/connect4_turn_controller.sv
// Move sequencer for 4x4 Connect4: samples column buttons, drops pieces into the board
// register, alternates players and detects win/draw. One move per press (RELEASE waits for 1111).
module connect4_turn_controller
  import connect4_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn_n,
  input  logic        new_game,
  output logic        drop_valid,
  output logic [4:0]  drop_position,
  output logic [31:0] board_state,
  output logic        current_player,
  output logic        illegal_move,
  output logic        game_over,
  output logic [1:0]  winner
);

  state_t                     state_q,  state_d;
  logic [1:0]                 col_q,    col_d;
  logic [31:0]                board_q,  board_d;
  logic [NUM_COLS-1:0][2:0]   height_q, height_d;
  logic [4:0]                 move_q,   move_d;
  logic                       player_q, player_d;
  logic                       illegal_q, illegal_d;
  logic [1:0]                 winner_q, winner_d;

  logic       btn_one;
  logic [1:0] btn_col;
  logic [3:0] drop_cell;
  logic       win;

  // Anything other than exactly one low bit is treated as no press at all.
  always_comb begin
    btn_one = 1'b1;
    btn_col = 2'd0;
    case (btn_n)
      4'b1110: btn_col = 2'd0;
      4'b1101: btn_col = 2'd1;
      4'b1011: btn_col = 2'd2;
      4'b0111: btn_col = 2'd3;
      default: btn_one = 1'b0;
    endcase
  end

  // In DROP the latched column is never full, so its height fits in two bits.
  assign drop_cell = {height_q[col_q][1:0], col_q};

  connect4_win_checker u_win_checker (
    .board_state (board_q),
    .cell_code   (player_cell(player_q)),
    .win         (win)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    board_d   = board_q;
    height_d  = height_q;
    move_d    = move_q;
    player_d  = player_q;
    illegal_d = 1'b0;
    winner_d  = winner_q;
    case (state_q)
      IDLE: begin
        if (btn_one) begin
          if (height_q[btn_col] < COL_FULL) begin
            col_d   = btn_col;
            state_d = DROP;
          end else begin
            illegal_d = 1'b1;
            state_d   = RELEASE;
          end
        end
      end
      DROP: begin
        board_d[{drop_cell, 1'b0} +: 2] = player_cell(player_q);
        if (height_q[col_q] < COL_FULL) height_d[col_q] = height_q[col_q] + 3'd1;
        if (move_q < MAX_MOVES)         move_d = move_q + 5'd1;
        state_d = CHECK;
      end
      CHECK: begin
        // A win on the last free cell outranks the draw.
        if (win) begin
          winner_d = player_cell(player_q);
          state_d  = OVER;
        end else if (move_q == MAX_MOVES) begin
          winner_d = WIN_DRAW;
          state_d  = OVER;
        end else begin
          player_d = ~player_q;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (btn_n == 4'b1111) state_d = IDLE;
      end
      OVER: begin
        state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= 2'd0;
      board_q   <= '0;
      height_q  <= '0;
      move_q    <= 5'd0;
      player_q  <= FIRST_PLAYER;
      illegal_q <= 1'b0;
      winner_q  <= WIN_NONE;
    end else if (new_game) begin
      state_q   <= IDLE;
      col_q     <= 2'd0;
      board_q   <= '0;
      height_q  <= '0;
      move_q    <= 5'd0;
      player_q  <= FIRST_PLAYER;
      illegal_q <= 1'b0;
      winner_q  <= WIN_NONE;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      board_q   <= board_d;
      height_q  <= height_d;
      move_q    <= move_d;
      player_q  <= player_d;
      illegal_q <= illegal_d;
      winner_q  <= winner_d;
    end
  end

  assign drop_valid     = (state_q == DROP);
  assign drop_position  = (state_q == DROP) ? {1'b0, drop_cell} : POS_INVALID;
  assign board_state    = board_q;
  assign current_player = player_q;
  assign illegal_move   = illegal_q;
  assign game_over      = (state_q == OVER);
  assign winner         = winner_q;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Bench for connect4_turn_controller: table vectors, directed game sequences and random
// games checked against an array-based model of the board and game rules.
module tb_connect4_turn_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn_n = 4'b1111;
  logic        new_game = 1'b0;
  logic        drop_valid;
  logic [4:0]  drop_position;
  logic [31:0] board_state;
  logic        current_player;
  logic        illegal_move;
  logic        game_over;
  logic [1:0]  winner;

  connect4_turn_controller #(.FIRST_PLAYER(1'b0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_n          (btn_n),
    .new_game       (new_game),
    .drop_valid     (drop_valid),
    .drop_position  (drop_position),
    .board_state    (board_state),
    .current_player (current_player),
    .illegal_move   (illegal_move),
    .game_over      (game_over),
    .winner         (winner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Model: mb[row][col] holds 0 empty, 1 A, 2 B.
  int mb[4][4];
  int mh[4];
  int mplayer, mcount, mwinner;
  bit mover;

  logic [4:0] last_pos;
  logic       last_drop, last_ill;

  typedef struct {
    logic [3:0] btn;
    logic       exp_drop;
    logic       exp_ill;
    logic [4:0] exp_pos;
  } vec_t;
  vec_t tbl[6];

  int draw_seq[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 4; r++) begin
      mh[r] = 0;
      for (int c = 0; c < 4; c++) mb[r][c] = 0;
    end
    mplayer = 0;
    mcount  = 0;
    mwinner = 0;
    mover   = 1'b0;
  endtask

  function automatic bit model_win(input int code);
    bit w, rl, cl, d1, d2;
    w  = 1'b0;
    d1 = 1'b1;
    d2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rl = 1'b1;
      cl = 1'b1;
      for (int j = 0; j < 4; j++) begin
        rl &= (mb[i][j] == code);
        cl &= (mb[j][i] == code);
      end
      w  |= rl | cl;
      d1 &= (mb[i][i] == code);
      d2 &= (mb[i][3-i] == code);
    end
    return w | d1 | d2;
  endfunction

  function automatic logic [31:0] model_board();
    logic [31:0] b;
    int v;
    b = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        v = mb[r][c];
        b[2*(r*4+c) +: 2] = v[1:0];
      end
    return b;
  endfunction

  // One button press on col, held for 'hold' extra cycles, then released; ends back in a quiet state.
  task automatic press(input int col, input int hold);
    logic [3:0] m;
    int code;
    bit dropped;
    m = 4'b0001 << col;
    dropped = 1'b0;
    @(negedge clk);
    btn_n = ~m;
    @(negedge clk);
    last_drop = drop_valid;
    last_pos  = drop_position;
    last_ill  = illegal_move;
    if (mover) begin
      chk("over_no_drop", {31'd0, drop_valid}, 32'd0);
      chk("over_no_illegal", {31'd0, illegal_move}, 32'd0);
    end else if (mh[col] == 4) begin
      chk("illegal_pulse", {31'd0, illegal_move}, 32'd1);
      chk("illegal_no_drop", {31'd0, drop_valid}, 32'd0);
    end else begin
      chk("drop_valid", {31'd0, drop_valid}, 32'd1);
      chk("drop_position", {27'd0, drop_position}, mh[col]*4 + col);
      code = mplayer + 1;
      mb[mh[col]][col] = code;
      mh[col]++;
      mcount++;
      dropped = 1'b1;
      if (model_win(code)) begin
        mwinner = code;
        mover   = 1'b1;
      end else if (mcount == 16) begin
        mwinner = 3;
        mover   = 1'b1;
      end else begin
        mplayer = 1 - mplayer;
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("held_no_drop", {31'd0, drop_valid}, 32'd0);
      chk("held_no_illegal", {31'd0, illegal_move}, 32'd0);
    end
    btn_n = 4'b1111;
    @(negedge clk);
    chk("pulse_cleared", {30'd0, illegal_move, drop_valid}, 32'd0);
    if (dropped && hold == 0) chk("board_at_n2", board_state, model_board());
    @(negedge clk);
    @(negedge clk);
    chk("board", board_state, model_board());
    chk("winner", {30'd0, winner}, mwinner);
    chk("current_player", {31'd0, current_player}, mplayer);
    chk("game_over", {31'd0, game_over}, {31'd0, mover});
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
    chk("ng_board", board_state, 32'd0);
    chk("ng_winner", {30'd0, winner}, 32'd0);
    chk("ng_player", {31'd0, current_player}, 32'd0);
    chk("ng_game_over", {31'd0, game_over}, 32'd0);
    chk("ng_drop_pos", {27'd0, drop_position}, 32'h1f);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b1111, 1'b0, 1'b0, 5'h1f};
    tbl[1] = '{4'b1100, 1'b0, 1'b0, 5'h1f};
    tbl[2] = '{4'b1010, 1'b0, 1'b0, 5'h1f};
    tbl[3] = '{4'b0000, 1'b0, 1'b0, 5'h1f};
    tbl[4] = '{4'b0011, 1'b0, 1'b0, 5'h1f};
    tbl[5] = '{4'b1001, 1'b0, 1'b0, 5'h1f};
    draw_seq = '{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1};
    model_reset();

    // Reset state.
    #12;
    chk("rst_drop_valid", {31'd0, drop_valid}, 32'd0);
    chk("rst_drop_pos", {27'd0, drop_position}, 32'h1f);
    chk("rst_board", board_state, 32'd0);
    chk("rst_player", {31'd0, current_player}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_move}, 32'd0);
    chk("rst_game_over", {31'd0, game_over}, 32'd0);
    chk("rst_winner", {30'd0, winner}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First press at column 0, held to prove a single drop per press.
    press(0, 3);
    chk("first_pos", {27'd0, last_pos}, 32'd0);
    chk("first_cell", {30'd0, board_state[1:0]}, 32'd1);
    chk("first_player", {31'd0, current_player}, 32'd1);

    // Column 2 fill then overflow.
    do_new_game();
    for (int i = 0; i < 4; i++) begin
      press(2, 0);
      chk("col2_pos", {27'd0, last_pos}, 2 + 4*i);
    end
    press(2, 0);
    chk("col2_full_illegal", {31'd0, last_ill}, 32'd1);
    chk("col2_full_nodrop", {31'd0, last_drop}, 32'd0);
    chk("col2_full_player", {31'd0, current_player}, 32'd0);

    // Invalid button patterns in IDLE.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn_n = tbl[i].btn;
      @(negedge clk);
      chk("tbl_drop", {31'd0, drop_valid}, {31'd0, tbl[i].exp_drop});
      chk("tbl_illegal", {31'd0, illegal_move}, {31'd0, tbl[i].exp_ill});
      chk("tbl_pos", {27'd0, drop_position}, {27'd0, tbl[i].exp_pos});
      btn_n = 4'b1111;
    end
    press(3, 0);
    chk("after_tbl_pos", {27'd0, last_pos}, 32'd3);

    // A wins vertically in column 0.
    do_new_game();
    for (int i = 0; i < 3; i++) begin
      press(0, 0);
      press(1, 0);
    end
    press(0, 0);
    chk("win_pos", {27'd0, last_pos}, 32'd12);
    chk("win_winner", {30'd0, winner}, 32'd1);
    chk("win_over", {31'd0, game_over}, 32'd1);
    press(2, 0);
    chk("win_ignored", {31'd0, last_drop}, 32'd0);

    // Full board without a line.
    do_new_game();
    for (int i = 0; i < 16; i++) press(draw_seq[i], 0);
    chk("draw_winner", {30'd0, winner}, 32'd3);
    chk("draw_over", {31'd0, game_over}, 32'd1);
    do_new_game();

    // Asynchronous reset while in DROP.
    press(1, 0);
    @(negedge clk);
    btn_n = 4'b1101;
    @(negedge clk);
    chk("pre_rst_drop", {31'd0, drop_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_drop_valid", {31'd0, drop_valid}, 32'd0);
    chk("async_drop_pos", {27'd0, drop_position}, 32'h1f);
    chk("async_board", board_state, 32'd0);
    chk("async_player", {31'd0, current_player}, 32'd0);
    @(negedge clk);
    chk("rst_hold_board", board_state, 32'd0);
    btn_n = 4'b1111;
    rst_n = 1'b1;
    model_reset();
    press(1, 0);
    chk("post_rst_pos", {27'd0, last_pos}, 32'd1);

    // Random games against the model.
    for (int g = 0; g < 6; g++) begin
      do_new_game();
      for (int m = 0; m < 22; m++) press($urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/connect4_turn_controller.md
Name: connect4_turn_controller

Overview:
- Sequences every move of the 4x4 Connect4 game: samples the active-low column buttons, alternates the two players, and tracks per-column fill height.
- Drops a piece into the board register, then checks for a 4-in-a-row win or a full-board draw.
- Sits between the debounced button inputs and the display/board consumers.
- Drop positions use the game's standard encoding: position = row*4 + column, row 0 at the bottom, 5'b11111 meaning "no position".

Parameters:
- FIRST_PLAYER, 1'b0: player who moves first after reset or new_game (0 = player A, 1 = player B).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_n  input  4  debounced column buttons, active-low, one-hot-low (1110 = col0, 1101 = col1, 1011 = col2, 0111 = col3).
- new_game  input  1  synchronous, active-high restart; takes priority over every other input.
- drop_valid  output  1  high for exactly one cycle when a piece is placed.
- drop_position  output  5  row*4+col of the placed piece while drop_valid = 1; 5'b11111 otherwise.
- board_state  output  32  cell p occupies bits [2p+1:2p]; 00 = empty, 01 = player A, 10 = player B.
- current_player  output  1  player whose turn it is.
- illegal_move  output  1  one-cycle pulse when a full column is pressed.
- game_over  output  1  high while in OVER.
- winner  output  2  00 = none, 01 = A, 10 = B, 11 = draw.

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE, board_state 0, column heights 0, move_count 0, current_player = FIRST_PLAYER, drop_valid 0, drop_position 5'b11111, illegal_move 0, game_over 0, winner 00.
- new_game = 1 on any edge: same values as reset, applied synchronously on that edge.
- State IDLE:
  - btn_n is sampled every edge.
  - If exactly one bit is low and that column height < 4: go to DROP and latch the column.
  - If exactly one bit is low and the column height == 4: illegal_move = 1 for the next cycle, go to RELEASE; player does not change.
  - 1111 or more than one low bit: stay in IDLE; no action, no pulse.
- State DROP (one cycle):
  - drop_valid = 1, drop_position = height*4 + col.
  - On the exiting edge: write the current player's code into that cell, increment that column's height (3 bits, saturates at 4, never wraps), increment move_count (5 bits, 0..16).
  - Next state CHECK.
- State CHECK (one cycle): evaluate the updated board for the current player over 4 rows, 4 columns and 2 diagonals.
  - Win: winner = current player code, go to OVER.
  - Else if move_count == 16: winner = 11, go to OVER.
  - Else: toggle current_player, go to RELEASE.
  - A win on the 16th move reports the win, not a draw.
- State RELEASE: stay until btn_n == 4'b1111, then go to IDLE. This enforces one move per press; a button held across turns is ignored.
- State OVER: game_over = 1; all buttons ignored; board_state and winner held until new_game or reset.
- Latency: press sampled at edge N → drop_valid high during cycle N+1 → board updated and visible from N+2 → winner/current_player updated from N+3.
- Reset mid-operation (DROP or CHECK): any partial write is discarded; all outputs return to reset values immediately.

Decomposition:
- Package connect4_pkg holds:
  - NUM_ROWS = 4, NUM_COLS = 4, POS_INVALID = 5'b11111.
  - Cell codes CELL_EMPTY / CELL_A / CELL_B.
  - Winner codes WIN_NONE / WIN_A / WIN_B / WIN_DRAW.
  - State enum IDLE, DROP, CHECK, RELEASE, OVER.
- One sub-module, connect4_win_checker: purely combinational; inputs board_state and a cell code, output win flag (10-line OR).
- The FSM, height counters and board register stay in the top module.

Test Plan:
- Reset, then btn_n = 1110 for one cycle → drop_valid pulse with drop_position = 0; cell0 = 01; current_player = 1 three cycles after the press; a held button causes no second drop until released.
- Alternate 5 presses into column 2 (releasing between each) → positions 2, 6, 10, 14; the 5th press gives illegal_move pulse, no drop_valid, player unchanged.
- Player A presses col0 ×4 while B presses col1 ×3 → after A's 4th drop (position 12), winner = 01, game_over = 1; further presses are ignored.
- btn_n = 1100 (two low) in IDLE → no drop, no illegal pulse, state remains IDLE.
- Fill all 16 cells in a non-winning order → after the 16th drop, winner = 11, game_over = 1; then new_game = 1 → board_state = 0, winner = 00, current_player = FIRST_PLAYER.
- Assert rst_n low during DROP → outputs reset asynchronously with no written cell; after release the first press lands at row 0.
